// File: rtl/ats21_client_port.sv
// ATS21 client command issuer: two-beat serializer with Ack/Nack retry,
// backoff and completion response, plus sticky alarm edge capture.
module ats21_client_port #(
  parameter int ACK_LAT     = 1,
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 4,
  parameter int NUM_ALARMS  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_data,
  output logic                  req,
  output logic [15:0]           ctrl,
  input  logic                  stat_in,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_ok,
  output logic [3:0]            resp_retries,
  input  logic [NUM_ALARMS-1:0] alarm_in,
  output logic [NUM_ALARMS-1:0] alarm_pending,
  input  logic [NUM_ALARMS-1:0] alarm_clear,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WAIT,
    S_BACKOFF,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [3:0]  retry_q, retry_d;
  logic [2:0]  wait_q, wait_d;
  logic [7:0]  boff_q, boff_d;
  logic        ok_q, ok_d;

  logic        cmd_ready_q;
  logic        req_q;
  logic [15:0] ctrl_q;
  logic        resp_valid_q;
  logic        resp_ok_q;
  logic [3:0]  resp_retries_q;

  logic [NUM_ALARMS-1:0] prev_q;
  logic [NUM_ALARMS-1:0] pend_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    retry_d = retry_q;
    wait_d  = wait_q;
    boff_d  = boff_q;
    ok_d    = ok_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d   = cmd_data;
          retry_d = 4'd0;
          if (cmd_data[31:29] == 3'b000) begin
            state_d = S_RESP;
            ok_d    = 1'b1;
          end else begin
            state_d = S_HI;
          end
        end
      end
      S_HI: state_d = S_LO;
      S_LO: begin
        state_d = S_WAIT;
        wait_d  = 3'(ACK_LAT);
      end
      S_WAIT: begin
        if (wait_q > 3'd1) begin
          wait_d = wait_q - 3'd1;
        end else begin
          wait_d = 3'd0;
          // opcodes x11 carry no status from the ATS21
          if (cmd_q[30:29] == 2'b11 || stat_in) begin
            state_d = S_RESP;
            ok_d    = 1'b1;
          end else if (retry_q == 4'(MAX_RETRY)) begin
            state_d = S_RESP;
            ok_d    = 1'b0;
          end else begin
            retry_d = retry_q + 4'd1;
            if (BACKOFF_CYC == 0) begin
              state_d = S_HI;
            end else begin
              state_d = S_BACKOFF;
              boff_d  = 8'(BACKOFF_CYC);
            end
          end
        end
      end
      S_BACKOFF: begin
        if (boff_q > 8'd1) begin
          boff_d = boff_q - 8'd1;
        end else begin
          boff_d  = 8'd0;
          state_d = S_HI;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cmd_q          <= '0;
      retry_q        <= '0;
      wait_q         <= '0;
      boff_q         <= '0;
      ok_q           <= 1'b0;
      cmd_ready_q    <= 1'b0;
      req_q          <= 1'b0;
      ctrl_q         <= '0;
      resp_valid_q   <= 1'b0;
      resp_ok_q      <= 1'b0;
      resp_retries_q <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      retry_q        <= retry_d;
      wait_q         <= wait_d;
      boff_q         <= boff_d;
      ok_q           <= ok_d;
      cmd_ready_q    <= (state_d == S_IDLE);
      req_q          <= (state_d == S_HI) || (state_d == S_LO);
      ctrl_q         <= (state_d == S_HI) ? cmd_d[31:16] :
                        (state_d == S_LO) ? cmd_d[15:0]  : 16'h0000;
      resp_valid_q   <= (state_d == S_RESP);
      resp_ok_q      <= (state_d == S_RESP) && ok_d;
      resp_retries_q <= (state_d == S_RESP) ? retry_d : 4'd0;
    end
  end

  // set beats clear when a rise and a clear coincide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= alarm_in;
      pend_q <= (alarm_in & ~prev_q) | (pend_q & ~alarm_clear);
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign req           = req_q;
  assign ctrl          = ctrl_q;
  assign resp_valid    = resp_valid_q;
  assign resp_ok       = resp_ok_q;
  assign resp_retries  = resp_retries_q;
  assign alarm_pending = pend_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ats21_client_port.sv
// Bench for ats21_client_port: directed plan steps plus random commands
// and alarm traffic checked against a behavioural model.
module tb_ats21_client_port;

  localparam int ACK  = 1;
  localparam int MAXR = 3;
  localparam int BOFF = 4;
  localparam int NA   = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_data;
  logic          req;
  logic [15:0]   ctrl;
  logic          stat_in;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_ok;
  logic [3:0]    resp_retries;
  logic [NA-1:0] alarm_in;
  logic [NA-1:0] alarm_pending;
  logic [NA-1:0] alarm_clear;
  logic          busy;

  int tests = 0;
  int fails = 0;

  ats21_client_port #(
    .ACK_LAT(ACK), .MAX_RETRY(MAXR),
    .BACKOFF_CYC(BOFF), .NUM_ALARMS(NA)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .req(req), .ctrl(ctrl),
    .stat_in(stat_in), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_ok(resp_ok),
    .resp_retries(resp_retries), .alarm_in(alarm_in),
    .alarm_pending(alarm_pending),
    .alarm_clear(alarm_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [31:0] c, input logic [15:0] pat,
                         input int rdly);
    logic [15:0] q[$];
    int pairs, er, lat, n, idx, exp_lat;
    logic eok, got, s_ok;
    logic [3:0] s_r;
    if (c[31:29] == 3'b000) begin
      pairs = 0; eok = 1'b1; er = 0;
    end else if (c[30:29] == 2'b11) begin
      pairs = 1; eok = 1'b1; er = 0;
    end else begin
      er = MAXR; eok = 1'b0;
      for (int k = MAXR; k >= 0; k--)
        if (pat[k]) begin er = k; eok = 1'b1; end
      pairs = er + 1;
    end
    exp_lat = pairs * (2 + ACK) + (pairs - 1) * BOFF + 1;
    stat_in = pat[0];
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = c;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 400 && !got) begin
      lat++;
      if (req) begin
        q.push_back(ctrl);
        if (q.size() % 2 == 0) begin
          idx = q.size() / 2 - 1;
          if (idx > 15) idx = 15;
          stat_in = pat[idx];
        end
      end
      if (resp_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk("resp_seen", 32'(got), 32'd1);
    if (pairs == 0) chk("nop_lat_le2", 32'(lat <= 2), 32'd1);
    else chk("latency", lat, exp_lat);
    chk("beat_count", q.size(), 2 * pairs);
    for (int i = 0; i < q.size(); i++)
      chk("beat", 32'(q[i]), (i % 2) ? 32'(c[15:0]) : 32'(c[31:16]));
    chk("resp_ok", 32'(resp_ok), 32'(eok));
    chk("resp_retries", 32'(resp_retries), er);
    s_ok = resp_ok;
    s_r  = resp_retries;
    repeat (rdly) begin
      @(negedge clk);
      chk("resp_hold", {resp_valid, resp_ok, resp_retries},
          {1'b1, s_ok, s_r});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", {resp_valid, busy, cmd_ready}, 32'b001);
  endtask

  initial begin
    logic [NA-1:0] m_prev, m_pend, ain, clr;
    logic any;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    stat_in = 1'b0;
    resp_ready = 1'b0;
    alarm_in = '0;
    alarm_clear = '0;
    #1;
    chk("rst_outs", {req, ctrl, cmd_ready, resp_valid, resp_ok,
        resp_retries, busy}, 32'd0);
    chk("rst_pending", 32'(alarm_pending), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 32'(cmd_ready), 32'd1);

    run_cmd(32'h2A40_0123, 16'h0001, 0);
    run_cmd(32'hA301_0010, 16'h0000, 2);
    run_cmd(32'hA301_0010, 16'h0002, 1);
    run_cmd(32'h0000_0000, 16'h0000, 0);
    run_cmd(32'hE380_0000, 16'h0000, 0);

    alarm_in[3] = 1'b1;
    alarm_clear[3] = 1'b1;
    @(negedge clk);
    alarm_clear[3] = 1'b0;
    chk("alarm_set_wins", 32'(alarm_pending[3]), 32'd1);
    repeat (2) @(negedge clk);
    chk("alarm_sticky", 32'(alarm_pending[3]), 32'd1);
    alarm_clear[3] = 1'b1;
    @(negedge clk);
    alarm_clear[3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("alarm_held_once", 32'(alarm_pending[3]), 32'd0);
    alarm_in = '0;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data = 32'h2A40_0123;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_lo_req", {req, ctrl}, {1'b1, 16'h0123});
    reset = 1'b1;
    #1;
    chk("async_rst", {req, ctrl, resp_valid, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_abort", 32'(cmd_ready), 32'd1);
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any = any | resp_valid | req;
    end
    chk("no_resp_after_abort", 32'(any), 32'd0);
    run_cmd(32'h2A40_0123, 16'h0001, 0);

    for (int t = 0; t < 20; t++)
      run_cmd($urandom, 16'($urandom_range(0, 15)), $urandom_range(0, 3));

    alarm_in = '0;
    alarm_clear = '1;
    @(negedge clk);
    @(negedge clk);
    m_prev = '0;
    m_pend = '0;
    for (int t = 0; t < 40; t++) begin
      ain = NA'($urandom);
      clr = NA'($urandom & $urandom);
      alarm_in = ain;
      alarm_clear = clr;
      m_pend = (m_pend & ~clr) | (ain & ~m_prev);
      m_prev = ain;
      @(negedge clk);
      chk("alarm_rand", 32'(alarm_pending), 32'(m_pend));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
